// File: rtl/bus_arbiter.sv
// One-hot registered bus arbiter: round-robin with optional CPU priority,
// a hold-time limit that preempts unlocked owners, and a one-cycle turnaround.
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8,
  parameter bit HI_PRIO0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic            preempt
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  localparam logic [IDW:0]    NREQ_W    = (IDW+1)'(NREQ);
  localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);
  localparam logic [3:0]      HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [3:0]      HOLD_MAX  = 4'(MAX_HOLD);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic            preempt_q, preempt_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]      hold_cnt_q, hold_cnt_d;

  logic [NREQ-1:0] rot;
  logic            win_found;
  logic [IDW:0]    win_sum;
  logic [IDW-1:0]  win_id;
  logic [IDW:0]    next_ptr;
  logic            owner_req, owner_lock, others_req;

  // Winner search: rotate requests so rr_ptr sits at bit 0, take the first set bit.
  always_comb begin
    rot       = NREQ'({req, req} >> rr_ptr_q);
    win_found = 1'b0;
    win_sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && rot[i]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      end
    end
    if (win_sum >= NREQ_W) win_sum = win_sum - NREQ_W;
    win_id = win_sum[IDW-1:0];
    if (HI_PRIO0 && req[0]) begin
      win_found = 1'b1;
      win_id    = '0;
    end
  end

  always_comb begin
    owner_req  = |(req & gnt_q);
    owner_lock = |(lock & gnt_q);
    others_req = |(req & ~gnt_q);
    next_ptr   = {1'b0, gnt_id_q} + (IDW+1)'(1);
    if (next_ptr >= NREQ_W) next_ptr = '0;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    unique case (state_q)
      IDLE, TURN: begin
        hold_cnt_d = '0;
        if (win_found) begin
          gnt_d    = ONE_HOT0 << win_id;
          gnt_id_d = win_id;
          state_d  = GRANT;
        end else begin
          gnt_d    = '0;
          gnt_id_d = '0;
          state_d  = IDLE;
        end
      end
      GRANT: begin
        hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 4'd1;
        // A dropped request always wins over the hold limit, so no preempt then.
        if (!owner_req ||
            (hold_cnt_q == HOLD_LAST && !owner_lock && others_req)) begin
          preempt_d  = owner_req;
          gnt_d      = '0;
          gnt_id_d   = '0;
          rr_ptr_d   = next_ptr[IDW-1:0];
          hold_cnt_d = '0;
          state_d    = TURN;
        end
      end
      default: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        state_d  = IDLE;
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
      rr_ptr_q    <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      preempt_q   <= preempt_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, each cycle
// compared with an owner/hold-time reference model.
module tb_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 8;
  localparam bit HI_PRIO0 = 1'b1;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] lock;
  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_id;
  logic            preempt;

  bus_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .MAX_HOLD(MAX_HOLD), .HI_PRIO0(HI_PRIO0)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .preempt(preempt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, how many cycles it has been visible,
  // where round-robin resumes, and whether a preempt pulse is due.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  bit m_pre   = 1'b0;

  task automatic model_edge();
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] l;
    int others;
    int w;
    r = req;
    l = lock;
    if (rst) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_pre = 1'b0;
    end else if (m_owner >= 0) begin
      m_held++;
      m_pre  = 1'b0;
      others = 0;
      for (int i = 0; i < NREQ; i++) if (i != m_owner && r[i]) others++;
      if (!r[m_owner] || (m_held == MAX_HOLD && !l[m_owner] && others > 0)) begin
        m_pre   = r[m_owner];
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_held  = 0;
      end
    end else begin
      m_pre = 1'b0;
      if (r != 0) begin
        w = -1;
        if (HI_PRIO0 && r[0]) w = 0;
        else
          for (int k = 0; k < NREQ; k++)
            if (w < 0 && r[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        m_owner = w;
        m_held  = 0;
      end
    end
  endtask

  function automatic logic [7:0] exp_vec();
    logic [NREQ-1:0] g;
    logic [IDW-1:0]  id;
    g  = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    id = (m_owner >= 0) ? IDW'(m_owner) : '0;
    return {g, (m_owner >= 0), id, m_pre};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; lock = '0;
    step();
    step();
    checks++;
    if ({gnt, gnt_valid, gnt_id, preempt} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", {gnt, gnt_valid, gnt_id, preempt}, 8'h00);
    end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if ({gnt, gnt_valid, gnt_id, preempt} !== exp_vec()) begin
        errors++;
        $display("FAIL single k=%0d got=%b exp=%b", k, {gnt, gnt_valid, gnt_id, preempt}, exp_vec());
      end
      if (k == 1) begin
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
          errors++;
          $display("FAIL single_latency gnt=%b id=%0d exp gnt=0001 id=0", gnt, gnt_id);
        end
      end
      if (k == 2) req = 4'b0000;
    end
  endtask

  task automatic test_prio_order();
    int order[$];
    int run;
    run = 0;
    do_reset();
    req = 4'b0111;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if ({gnt, gnt_valid, gnt_id, preempt} !== exp_vec()) begin
        errors++;
        $display("FAIL prio_order k=%0d got=%b exp=%b", k, {gnt, gnt_valid, gnt_id, preempt}, exp_vec());
      end
      if (gnt_valid) begin
        if (run == 0) order.push_back(int'(gnt_id));
        run++;
      end
      if (m_owner >= 0 && m_held == 1) begin
        req[m_owner] = 1'b0;
        run = 0;
      end
    end
    checks++;
    if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
      errors++;
      $display("FAIL prio_order_seq got size=%0d first=%0d exp 0,1,2", order.size(),
               (order.size() > 0) ? order[0] : -1);
    end
  endtask

  task automatic test_preempt();
    int pre_cnt;
    pre_cnt = 0;
    do_reset();
    req = 4'b1010;
    for (int k = 1; k <= 40; k++) begin
      step();
      checks++;
      if ({gnt, gnt_valid, gnt_id, preempt} !== exp_vec()) begin
        errors++;
        $display("FAIL preempt k=%0d got=%b exp=%b", k, {gnt, gnt_valid, gnt_id, preempt}, exp_vec());
      end
      if (preempt === 1'b1) pre_cnt++;
      if (k == 8 || k == 9 || k == 10) begin
        checks++;
        if ((k == 8 && gnt !== 4'b0010) || (k == 9 && {gnt, preempt} !== 5'b00001) ||
            (k == 10 && {gnt, preempt} !== 5'b10000)) begin
          errors++;
          $display("FAIL preempt_edge k=%0d gnt=%b preempt=%b", k, gnt, preempt);
        end
      end
    end
    checks++;
    if (pre_cnt != 4) begin
      errors++;
      $display("FAIL preempt_count got=%0d exp=4", pre_cnt);
    end
  endtask

  task automatic test_lock();
    int run_len;
    int pre_cnt;
    run_len = 0; pre_cnt = 0;
    do_reset();
    req = 4'b1100; lock = 4'b0100;
    for (int k = 1; k <= 25; k++) begin
      step();
      checks++;
      if ({gnt, gnt_valid, gnt_id, preempt} !== exp_vec()) begin
        errors++;
        $display("FAIL lock k=%0d got=%b exp=%b", k, {gnt, gnt_valid, gnt_id, preempt}, exp_vec());
      end
      if (gnt === 4'b0100) run_len++;
      if (preempt === 1'b1) pre_cnt++;
      if (k == 20) req[2] = 1'b0;
      if (k == 22) begin
        checks++;
        if (gnt !== 4'b1000) begin
          errors++;
          $display("FAIL lock_next gnt=%b exp=1000", gnt);
        end
      end
    end
    checks++;
    if (run_len != 20 || pre_cnt != 0) begin
      errors++;
      $display("FAIL lock_hold run=%0d exp=20 preempts=%0d exp=0", run_len, pre_cnt);
    end
    lock = '0;
  endtask

  task automatic test_drop_at_limit();
    do_reset();
    req = 4'b1010;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if ({gnt, gnt_valid, gnt_id, preempt} !== exp_vec()) begin
        errors++;
        $display("FAIL drop_limit k=%0d got=%b exp=%b", k, {gnt, gnt_valid, gnt_id, preempt}, exp_vec());
      end
      if (k == 8) req[1] = 1'b0;
      if ((k == 9 && {gnt, preempt} !== 5'b00000) || (k == 10 && gnt !== 4'b1000)) begin
        errors++;
        $display("FAIL drop_limit_edge k=%0d gnt=%b preempt=%b", k, gnt, preempt);
      end
      if (k == 9 || k == 10) checks++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL rst_mid_pre gnt=%b exp=0100", gnt);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({gnt, gnt_valid, gnt_id, preempt} !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_clear got=%b exp=00000000", {gnt, gnt_valid, gnt_id, preempt});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({gnt, gnt_valid, gnt_id, preempt} !== exp_vec() || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL rst_mid_regrant got=%b exp=%b", {gnt, gnt_valid, gnt_id, preempt}, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 11) == 0) req[i]  = ~req[i];
        if ($urandom_range(0, 19) == 0) lock[i] = ~lock[i];
      end
      rst = ($urandom_range(0, 149) == 0);
      step();
      checks++;
      if ({gnt, gnt_valid, gnt_id, preempt} !== exp_vec() || !$onehot0(gnt)) begin
        errors++;
        $display("FAIL random k=%0d req=%b lock=%b got=%b exp=%b", k, req, lock,
                 {gnt, gnt_valid, gnt_id, preempt}, exp_vec());
      end
    end
    rst = 1'b0; req = '0; lock = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0;
    test_reset();
    test_single();
    test_prio_order();
    test_preempt();
    test_lock();
    test_drop_at_limit();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
